// File: rtl/updown_button_conditioner.sv
// ============================================================================
// updown_button_conditioner: sync + debounce two buttons into inc/dec pulses.
// Optional auto-repeat when AUTO_REPEAT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module updown_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic increment,
  output logic decrement,
  output logic up_level,
  output logic down_level,
  output logic conflict
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             up_s1, up_s2, dn_s1, dn_s2;
  logic [CNT_W-1:0] up_cnt, dn_cnt;

  // Next-level and rise terms are shared by the debounce and pulse logic.
  logic up_flip, dn_flip, up_next, dn_next, rise_up, rise_dn;
  assign up_flip = (up_s2 != up_level) && (up_cnt == DB_LAST);
  assign dn_flip = (dn_s2 != down_level) && (dn_cnt == DB_LAST);
  assign up_next = up_flip ? up_s2 : up_level;
  assign dn_next = dn_flip ? dn_s2 : down_level;
  assign rise_up = up_flip && up_s2;
  assign rise_dn = dn_flip && dn_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      up_s1      <= 1'b0;
      up_s2      <= 1'b0;
      dn_s1      <= 1'b0;
      dn_s2      <= 1'b0;
      up_cnt     <= '0;
      dn_cnt     <= '0;
      up_level   <= 1'b0;
      down_level <= 1'b0;
    end else begin
      up_s1    <= btn_up;
      up_s2    <= up_s1;
      dn_s1    <= btn_down;
      dn_s2    <= dn_s1;
      up_level <= up_next;
      down_level <= dn_next;
      if (up_s2 == up_level || up_flip) up_cnt <= '0;
      else                              up_cnt <= up_cnt + 1'b1;
      if (dn_s2 == down_level || dn_flip) dn_cnt <= '0;
      else                                dn_cnt <= dn_cnt + 1'b1;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rep_state_t;

  rep_state_t       rep_state;
  logic [CNT_W-1:0] rep_cnt;
  logic             held_up;

  logic start_up, start_dn, held_next, other_next, rep_abort, rep_fire;
  assign start_up   = rise_up && !rise_dn && !dn_next;
  assign start_dn   = rise_dn && !rise_up && !up_next;
  assign held_next  = held_up ? up_next : dn_next;
  assign other_next = held_up ? dn_next : up_next;
  assign rep_abort  = !held_next || other_next;
  assign rep_fire   = !rep_abort &&
                      (((rep_state == DELAY)  && (rep_cnt == RD_LAST)) ||
                       ((rep_state == REPEAT) && (rep_cnt == RP_LAST)));

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_state <= IDLE;
      rep_cnt   <= '0;
      held_up   <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      increment <= (rise_up && !rise_dn) || (rep_fire && held_up);
      decrement <= (rise_dn && !rise_up) || (rep_fire && !held_up);
      conflict  <= rise_up && rise_dn;
      if (start_up || start_dn) begin
        rep_state <= DELAY;
        rep_cnt   <= '0;
        held_up   <= start_up;
      end else if (rep_state != IDLE && rep_abort) begin
        rep_state <= IDLE;
        rep_cnt   <= '0;
      end else begin
        case (rep_state)
          DELAY: begin
            if (rep_cnt == RD_LAST) begin
              rep_state <= REPEAT;
              rep_cnt   <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rep_cnt == RP_LAST) rep_cnt <= '0;
            else                    rep_cnt <= rep_cnt + 1'b1;
          end
          default: rep_cnt <= '0;
        endcase
      end
    end
  end
`else
  wire unused_repeat_cfg = (REPEAT_DELAY != REPEAT_PERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      increment <= 1'b0;
      decrement <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      increment <= rise_up && !rise_dn;
      decrement <= rise_dn && !rise_up;
      conflict  <= rise_up && rise_dn;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_button_conditioner.sv
// ============================================================================
// tb_updown_button_conditioner: directed + random stimulus vs. window model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_updown_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic increment, decrement, up_level, down_level, conflict;

  int tests = 0;
  int fails = 0;

  updown_button_conditioner #(
    .DEBOUNCE_CYCLES(D), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .increment(increment), .decrement(decrement),
    .up_level(up_level), .down_level(down_level), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last D synchronised samples all
  // disagree with it; samples reach the debouncer two edges after capture.
  bit up_q[$], dn_q[$], up_h[$], dn_h[$];
  bit m_up, m_dn, m_inc, m_dec, m_con;
  int rep_btn, age;

  always @(posedge clk) begin
    bit su, sd, nu, nd, ru, rdn, ok, held, other;
    if (reset) begin
      up_q = '{1'b0, 1'b0};
      dn_q = '{1'b0, 1'b0};
      up_h.delete();
      dn_h.delete();
      m_up = 0; m_dn = 0; m_inc = 0; m_dec = 0; m_con = 0;
      rep_btn = 0; age = 0;
    end else begin
      su = up_q.pop_front(); up_q.push_back(btn_up);
      sd = dn_q.pop_front(); dn_q.push_back(btn_down);
      up_h.push_back(su); if (up_h.size() > D) void'(up_h.pop_front());
      dn_h.push_back(sd); if (dn_h.size() > D) void'(dn_h.pop_front());
      nu = m_up;
      ok = (up_h.size() == D);
      foreach (up_h[i]) if (up_h[i] == m_up) ok = 0;
      if (ok) nu = !m_up;
      nd = m_dn;
      ok = (dn_h.size() == D);
      foreach (dn_h[i]) if (dn_h[i] == m_dn) ok = 0;
      if (ok) nd = !m_dn;
      ru  = nu && !m_up;
      rdn = nd && !m_dn;
      m_inc = ru && !rdn;
      m_dec = rdn && !ru;
      m_con = ru && rdn;
`ifdef AUTO_REPEAT_EN
      if (ru && !rdn && !nd) begin rep_btn = 1; age = 0; end
      else if (rdn && !ru && !nu) begin rep_btn = 2; age = 0; end
      else if (rep_btn != 0) begin
        held  = (rep_btn == 1) ? nu : nd;
        other = (rep_btn == 1) ? nd : nu;
        if (!held || other) rep_btn = 0;
        else begin
          age++;
          if (age == RD || (age > RD && (age - RD) % RP == 0)) begin
            if (rep_btn == 1) m_inc = 1; else m_dec = 1;
          end
        end
      end
`endif
      m_up = nu;
      m_dn = nd;
    end
    #1;
    check("increment", increment, m_inc);
    check("decrement", decrement, m_dec);
    check("conflict", conflict, m_con);
    check("up_level", up_level, m_up);
    check("down_level", down_level, m_dn);
    check("inc_dec_exclusive", increment && decrement, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from an input change until increment is seen (bounded).
  task automatic measure_inc_latency(input string tag);
    int k;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk); #2;
      if (increment) break;
    end
    check(tag, k, D + 2);
  endtask

  initial begin
    tick(3);
    reset = 0;
    tick(2);

    // Single clean press: pulse follows edge N+1+D.
    btn_up = 1;
    measure_inc_latency("press_latency");
    tick(20);
    btn_up = 0;
    tick(15);

    // Two short glitches on down never reach the level.
    repeat (2) begin
      btn_down = 1; tick(3);
      btn_down = 0; tick(3);
    end
    tick(10);

    // Simultaneous press.
    btn_up = 1; btn_down = 1;
    tick(20);
    btn_up = 0; btn_down = 0;
    tick(15);

    // Down pressed while up is held.
    btn_up = 1;
    tick(20);
    btn_down = 1;
    tick(20);
    btn_up = 0; btn_down = 0;
    tick(15);

    // Reset mid-debounce restarts the count.
    btn_up = 1;
    tick(3);
    reset = 1;
    tick(1);
    reset = 0;
    measure_inc_latency("post_reset_latency");
    tick(10);
    btn_up = 0;
    tick(15);

    // Long hold (auto-repeat behaviour when enabled).
    btn_up = 1;
    tick(40);
    btn_up = 0;
    tick(20);

    repeat (160) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) reset = 1;
      tick(1);
      reset = 0;
      if ($urandom_range(0, 1) == 1) tick($urandom_range(0, 5));
      else                           tick($urandom_range(6, 35));
    end
    btn_up = 0; btn_down = 0;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
